// File: rtl/d_pipe_pkg.sv
// rtl/d_pipe_pkg.sv - shared constants, stage record type and width helper for d_pipe
package d_pipe_pkg;

  localparam int D_PIPE_DEFAULT_WIDTH = 4;
  localparam int D_PIPE_DEFAULT_DEPTH = 3;

  // One stage's contents at the default width: {valid, data}.
  typedef struct packed {
    logic                            valid;
    logic [D_PIPE_DEFAULT_WIDTH-1:0] data;
  } d_pipe_rec_t;

  // Ceiling log2, used to size the occupancy count (needs to hold 0..DEPTH).
  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/d_pipe_stage.sv
// rtl/d_pipe_stage.sv - one valid/data register of the d_pipe delay line
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset (clears valid and data)
//   flush     synchronous clear of valid; data holds
//   up_valid  upstream word present
//   up_data   upstream word
//   dn_ready  downstream stage (or consumer) can take this stage's word
//   ready_out this stage loads from upstream this cycle
//   valid     stage holds a word
//   data      stage word (holds its last value when valid=0)
module d_pipe_stage
  import d_pipe_pkg::*;
#(
  parameter int WIDTH = D_PIPE_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             ready_out,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;

  // An empty stage always loads, which is what collapses bubbles under a stall.
  assign ready_out = !valid_q || dn_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (ready_out) begin
      valid_d = up_valid;
      // Bubbles pass through without disturbing the data register.
      if (up_valid) begin
        data_d = up_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/d_pipe.sv
// rtl/d_pipe.sv - DEPTH-stage valid/ready register pipeline with bubble collapse and flush
// Optional feature macro: D_PIPE_COUNT_EN (adds the occupancy output).
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset; discards all words
//   flush      synchronous clear of all stage valid bits; blocks input that cycle
//   in_valid   upstream word present
//   in_ready   pipe accepts a word this cycle
//   in_data    upstream word
//   out_valid  word present at the last stage
//   out_ready  downstream accepts
//   out_data   last-stage word
//   occupancy  number of resident words, 0..DEPTH (D_PIPE_COUNT_EN only)
module d_pipe
  import d_pipe_pkg::*;
#(
  parameter int WIDTH = D_PIPE_DEFAULT_WIDTH,
  parameter int DEPTH = D_PIPE_DEFAULT_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data
`ifdef D_PIPE_COUNT_EN
  ,
  output logic [clog2(DEPTH+1)-1:0]   occupancy
`endif
);

  // ready[i] is the load enable of stage i; ready[DEPTH] is the consumer.
  logic [DEPTH:0]   ready;
  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] data [DEPTH];

  assign ready[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      d_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .up_valid  (in_valid),
        .up_data   (in_data),
        .dn_ready  (ready[i+1]),
        .ready_out (ready[i]),
        .valid     (valid[i]),
        .data      (data[i])
      );
    end else begin : g_body
      d_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .up_valid  (valid[i-1]),
        .up_data   (data[i-1]),
        .dn_ready  (ready[i+1]),
        .ready_out (ready[i]),
        .valid     (valid[i]),
        .data      (data[i])
      );
    end
  end

  // A flush cycle drops everything, so a word taken then would be lost.
  assign in_ready  = ready[0] && !flush;
  assign out_valid = valid[DEPTH-1];
  assign out_data  = data[DEPTH-1];

`ifdef D_PIPE_COUNT_EN
  localparam int OCC_W = clog2(DEPTH + 1);

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(valid[i]);
    end
  end
`endif

endmodule

// File: tb/tb_d_pipe.sv
// tb/tb_d_pipe.sv - randomized and directed self-checking bench for d_pipe
module tb_d_pipe;
  import d_pipe_pkg::*;

  localparam int WIDTH = D_PIPE_DEFAULT_WIDTH;
  localparam int DEPTH = D_PIPE_DEFAULT_DEPTH;
  localparam int OCC_W = clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_data, out_data;
`ifdef D_PIPE_COUNT_EN
  logic [OCC_W-1:0] occupancy;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  d_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef D_PIPE_COUNT_EN
    ,
    .occupancy (occupancy)
`endif
  );

  // Reference model: resident words in order (head = oldest) with the stage
  // position each one occupies. Each edge a word moves one place forward
  // unless it would run into the word ahead of it or off the end.
  logic [WIDTH-1:0] m_data[$];
  int               m_pos[$];
  int               m_npos[$];
  logic [WIDTH-1:0] m_last;
  bit               m_pop;
  logic             e_in_ready;
  d_pipe_rec_t      e_out;
  int               e_occ;

  task automatic predict();
    int lim;
    e_out.valid = (m_pos.size() > 0) && (m_pos[0] == DEPTH - 1);
    e_out.data  = e_out.valid ? m_data[0] : m_last;
    e_occ       = m_pos.size();
    m_pop       = e_out.valid && out_ready;
    m_npos.delete();
    lim = DEPTH - 1;
    for (int k = m_pop ? 1 : 0; k < m_pos.size(); k++) begin
      int np;
      np  = (m_pos[k] + 1 < lim) ? m_pos[k] + 1 : lim;
      m_npos.push_back(np);
      lim = np - 1;
    end
    e_in_ready = !flush && (m_npos.size() == 0 || m_npos[m_npos.size()-1] > 0);
  endtask

  task automatic commit();
    if (reset) begin
      m_data.delete();
      m_pos.delete();
      m_last = '0;
    end else if (flush) begin
      m_data.delete();
      m_pos.delete();
    end else begin
      if (m_pop) m_data.delete(0);
      m_pos = m_npos;
      if (in_valid && e_in_ready) begin
        m_data.push_back(in_data);
        m_pos.push_back(0);
      end
      if (m_pos.size() > 0 && m_pos[0] == DEPTH - 1) m_last = m_data[0];
    end
  endtask

  task automatic drive(input logic rs, input logic fl, input logic iv,
                       input logic [WIDTH-1:0] id, input logic ordy);
    @(negedge clk);
    reset = rs; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    predict();
  endtask

  task automatic tick();
    @(posedge clk);
    commit();
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checks++;
    if ({in_ready, out_valid, out_data} !== {1'b1, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL reset_state ready/valid/data got %b/%b/%h want 1/0/0", in_ready, out_valid, out_data);
    end
`ifdef D_PIPE_COUNT_EN
    checks++;
    if (occupancy !== '0) begin
      errors++; $display("FAIL reset_occ got %0d want 0", occupancy);
    end
`endif
    tick();
  endtask

  task automatic test_streaming();
    logic [WIDTH-1:0] seen[$];
    int first = -1;
    int last  = -1;
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b0, c < 4, WIDTH'(c + 1), 1'b1);
      checks++;
      if ({in_ready, out_valid, out_data} !== {e_in_ready, e_out}) begin
        errors++;
        $display("FAIL stream_model t=%0t ready/valid/data got %b/%b/%h want %b/%b/%h",
                 $time, in_ready, out_valid, out_data, e_in_ready, e_out.valid, e_out.data);
      end
      if (out_valid === 1'b1) begin
        if (first < 0) first = c;
        last = c;
        seen.push_back(out_data);
      end
      tick();
    end
    checks++;
    if (first != 3) begin errors++; $display("FAIL stream_latency got %0d want 3", first); end
    checks++;
    if (seen.size() != 4 || last - first != 3) begin
      errors++; $display("FAIL stream_count got %0d words over %0d cycles want 4 over 4", seen.size(), last - first + 1);
    end
    for (int k = 0; k < seen.size(); k++) begin
      checks++;
      if (seen[k] !== WIDTH'(k + 1)) begin
        errors++; $display("FAIL stream_data[%0d] got %h want %h", k, seen[k], k + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] words[4];
    logic [WIDTH-1:0] seen[$];
    int idx = 0;
    words[0] = 4'hA; words[1] = 4'hB; words[2] = 4'hC; words[3] = 4'hD;
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 1'b0, 1'b1, words[idx < 4 ? idx : 3], 1'b0);
      checks++;
      if ({in_ready, out_valid, out_data} !== {e_in_ready, e_out}) begin
        errors++;
        $display("FAIL bp_fill_model t=%0t ready/valid/data got %b/%b/%h want %b/%b/%h",
                 $time, in_ready, out_valid, out_data, e_in_ready, e_out.valid, e_out.data);
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    drive(1'b0, 1'b0, 1'b1, words[idx < 4 ? idx : 3], 1'b0);
    checks++;
    if (idx != 3 || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full accepted %0d in_ready %b want 3 and 0", idx, in_ready);
    end
    checks++;
    if ({out_valid, out_data} !== {1'b1, 4'hA}) begin
      errors++; $display("FAIL bp_head got %b/%h want 1/a", out_valid, out_data);
    end
`ifdef D_PIPE_COUNT_EN
    checks++;
    if (occupancy !== OCC_W'(3)) begin
      errors++; $display("FAIL bp_occ got %0d want 3", occupancy);
    end
`endif
    tick();
    for (int c = 0; c < 20 && seen.size() < 4; c++) begin
      drive(1'b0, 1'b0, idx < 4, words[idx < 4 ? idx : 3], 1'b1);
      if (c == 0) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL bp_release_ready got %b want 1", in_ready);
        end
      end
      checks++;
      if ({in_ready, out_valid, out_data} !== {e_in_ready, e_out}) begin
        errors++;
        $display("FAIL bp_drain_model t=%0t ready/valid/data got %b/%b/%h want %b/%b/%h",
                 $time, in_ready, out_valid, out_data, e_in_ready, e_out.valid, e_out.data);
      end
      if (out_valid === 1'b1) seen.push_back(out_data);
      if (in_valid && in_ready) idx++;
      tick();
    end
    checks++;
    if (seen.size() != 4) begin
      errors++; $display("FAIL bp_count got %0d want 4", seen.size());
    end
    for (int k = 0; k < seen.size() && k < 4; k++) begin
      checks++;
      if (seen[k] !== words[k]) begin
        errors++; $display("FAIL bp_order[%0d] got %h want %h", k, seen[k], words[k]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_no_repeat got out_valid %b want 0", out_valid);
    end
    tick();
  endtask

  task automatic test_bubble();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0); tick();
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b0, c == 0 || c == 3, (c == 0) ? 4'h5 : 4'h6, 1'b0);
      checks++;
      if ({in_ready, out_valid, out_data} !== {e_in_ready, e_out}) begin
        errors++;
        $display("FAIL bubble_model t=%0t ready/valid/data got %b/%b/%h want %b/%b/%h",
                 $time, in_ready, out_valid, out_data, e_in_ready, e_out.valid, e_out.data);
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if ({in_ready, out_valid, out_data} !== {1'b1, 1'b1, 4'h5}) begin
      errors++; $display("FAIL bubble_packed got %b/%b/%h want 1/1/5", in_ready, out_valid, out_data);
    end
`ifdef D_PIPE_COUNT_EN
    checks++;
    if (occupancy !== OCC_W'(2)) begin
      errors++; $display("FAIL bubble_occ got %0d want 2", occupancy);
    end
`endif
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1); tick();
    // Word 6 sits right behind 5, so it reaches the output one cycle after 5 leaves.
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checks++;
    if ({out_valid, out_data} !== {1'b1, 4'h6}) begin
      errors++; $display("FAIL bubble_next got %b/%h want 1/6", out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_flush();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 1'b1, WIDTH'(7 + c), 1'b0);
      tick();
    end
    drive(1'b0, 1'b1, 1'b1, 4'hE, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready got %b want 0", in_ready);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_valid got %b want 0", out_valid);
    end
`ifdef D_PIPE_COUNT_EN
    checks++;
    if (occupancy !== '0) begin
      errors++; $display("FAIL flush_occ got %0d want 0", occupancy);
    end
`endif
    tick();
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
      checks++;
      if ({in_ready, out_valid, out_data} !== {e_in_ready, e_out} || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_idle t=%0t ready/valid/data got %b/%b/%h want %b/0/%h",
                 $time, in_ready, out_valid, out_data, e_in_ready, e_out.data);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b0, 1'b1, 4'h3, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b1, 4'h9, 1'b1); tick();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1); tick();
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
      checks++;
      if ({out_valid, out_data} !== {1'b0, 4'h0}) begin
        errors++; $display("FAIL reset_mid c=%0d got %b/%h want 0/0", c, out_valid, out_data);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic             iv = 1'b0;
    logic [WIDTH-1:0] id = '0;
    logic             hold = 1'b0;
    int               ordy_pct = 50;
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0); tick();
    for (int c = 0; c < 600; c++) begin
      if (c % 32 == 0) ordy_pct = ($urandom_range(0, 2) == 0) ? 15 : (($urandom_range(0, 1) == 0) ? 50 : 95);
      if (!hold) begin
        iv = ($urandom_range(0, 3) != 0);
        id = WIDTH'($urandom);
      end
      drive($urandom_range(0, 149) == 0, $urandom_range(0, 39) == 0, iv, id,
            $urandom_range(0, 99) < ordy_pct);
      checks++;
      if ({in_ready, out_valid, out_data} !== {e_in_ready, e_out}) begin
        errors++;
        $display("FAIL rand_model c=%0d ready/valid/data got %b/%b/%h want %b/%b/%h",
                 c, in_ready, out_valid, out_data, e_in_ready, e_out.valid, e_out.data);
      end
`ifdef D_PIPE_COUNT_EN
      checks++;
      if (occupancy !== OCC_W'(e_occ)) begin
        errors++; $display("FAIL rand_occ c=%0d got %0d want %0d", c, occupancy, e_occ);
      end
`endif
      hold = iv && !in_ready;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    m_last = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/d_pipe.md
Name: d_pipe

Overview:
- Parametrised successor to the single-stage D register.
- A DEPTH-stage, WIDTH-bit register pipeline with per-stage valid bits, valid/ready flow control, bubble collapsing and a synchronous flush.
- Used as a retiming delay line between producer and consumer blocks that may stall.
- Throughput is one word per cycle. Data is never dropped or duplicated under back-pressure.

Parameters:
- WIDTH, 4, data width in bits (>=1).
- DEPTH, 3, number of register stages (>=1); unstalled latency in cycles.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of all stage valid bits.
- in_valid  input  1  upstream word present.
- in_ready  output  1  pipe accepts a word this cycle.
- in_data  input  WIDTH  upstream word.
- out_valid  output  1  word present at the last stage.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  last-stage word.
- occupancy  output  $clog2(DEPTH+1)  present only with D_PIPE_COUNT_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. Priority order is reset > flush > normal transfer.
- State: stages s[0..DEPTH-1]; each stage holds v[i] (1 bit) and q[i] (WIDTH bits).
- Ready chain (combinational):
  - r[DEPTH] = out_ready.
  - r[i] = !v[i] || r[i+1].
  - in_ready = r[0] && !flush.
- Transfer on each clk edge, for stage i where r[i]=1:
  - Upstream is in_valid/in_data for i=0, and v[i-1]/q[i-1] otherwise.
  - v[i] <= upstream valid.
  - q[i] <= upstream data only when upstream valid=1; otherwise q[i] holds.
- Stall: when r[i]=0, stage i holds both v[i] and q[i].
- Handshakes: a transfer occurs when in_valid && in_ready on input, and when out_valid && out_ready on output.
- Latency: with out_ready held high and no flush, a word accepted at edge k appears on out_valid/out_data after edge k+DEPTH-1, i.e. it is visible DEPTH cycles after being presented.
- Bubble collapse: an empty stage accepts from upstream even when downstream is stalled. A stalled pipe therefore fills fully to DEPTH words before in_ready drops.
- Outputs: out_valid = v[DEPTH-1]; out_data = q[DEPTH-1]. When out_valid=0, out_data holds its last value.
- Reset: all v[i]=0 and all q[i]=0. Consequently out_valid=0, out_data=0, and in_ready=1 (when flush=0). occupancy=0.
- Flush: all v[i] <= 0 and q[i] hold. in_ready=0 in the flush cycle; in_data is not captured and the upstream must re-present it. An out_valid && out_ready in the same cycle still counts as consumed by downstream.
- Full pipe: with out_ready=0, in_ready=0. When out_ready rises, in_ready=1 in the same cycle, so a simultaneous push and pop keeps the pipe full.
- Reset mid-operation: all in-flight words are discarded. No output appears after reset until new words are accepted.
- DEPTH=1: behaves as a single register with valid and flow control.
- Input assumption: in_data and in_valid are stable while in_valid && !in_ready. out_valid/out_data are guaranteed stable while out_valid && !out_ready.

Optional Feature:
- Macro: D_PIPE_COUNT_EN.
- Defined: adds the occupancy port, equal to the popcount of v[0..DEPTH-1], derived combinationally from registered state. Range is 0..DEPTH; it is 0 after reset or flush.
- Undefined: no occupancy port and no counting logic; all other behaviour is identical.

Decomposition:
- Shared package d_pipe_pkg:
  - default WIDTH/DEPTH constants.
  - function clog2 for the occupancy width.
  - typedef for the stage record {valid, data}.
- One sub-module, d_pipe_stage: a single valid/data register with up_valid, up_data, dn_ready, ready_out, flush and reset inputs.
- d_pipe instantiates d_pipe_stage DEPTH times in a generate loop and chains the ready signals.

Test Plan (WIDTH=4, DEPTH=3):
- Reset: reset=1 for 2 cycles -> out_valid=0, out_data=0, in_ready=1, occupancy=0.
- Streaming: out_ready=1; push 0x1,0x2,0x3,0x4 on consecutive cycles -> out_data reads 0x1..0x4 on consecutive cycles starting 3 cycles after the first push; no gaps.
- Back-pressure fill: out_ready=0; push 0xA,0xB,0xC,0xD -> 0xA,0xB,0xC are accepted and in_ready=0 while 0xD is held; occupancy=3. Raising out_ready -> 0xA,0xB,0xC,0xD all emerge in order, none lost or repeated.
- Bubble collapse: push 0x5, idle 2 cycles, push 0x6, all with out_ready=0 -> both words are packed into stages 2 and 1, and occupancy=2.
- Flush: with 3 words resident, assert flush for 1 cycle while in_valid=1 with 0xE -> in_ready=0, out_valid=0 next cycle, occupancy=0, and 0xE does not appear.
- Reset mid-stream: assert reset while 2 words are in flight -> out_valid=0 from the next edge, and no stale word emerges afterward.
